issue_scoreboard: RTL

- Issue-stage hazard controller between the decoder outputs and the execute pipeline.
- Tracks in-flight register writes from the ALU, load and 5-stage multiplier paths, and reserves the single register-file write port.
- Raises a combinational stall for RAW, WAW and write-port conflicts, so decoded instructions issue only when safe.
- Sequences issue for all downstream pipelines.

---
 rtl/issue_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: issue-stage hazard controller.
// Tracks pending register writes and the shared write port.
module issue_scoreboard #(
  parameter int N_REGS  = 32,
  parameter int MUL_LAT = 5,
  parameter int LD_USE  = 2,
  parameter int WB_ALU  = 3,
  parameter int WB_MUL  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [4:0]        dec_r1,
  input  logic [4:0]        dec_r2,
  input  logic              dec_uses_r1,
  input  logic              dec_uses_r2,
  input  logic [4:0]        dec_dst,
  input  logic              dec_flag_reg,
  input  logic              dec_flag_mul,
  input  logic              dec_flag_mem,
  input  logic              dec_flag_store,
  input  logic              pipe_freeze,
  output logic              stall,
  output logic              issue,
  output logic [N_REGS-1:0] busy_regs
);

  localparam int CW = $clog2(MUL_LAT + 1);

  // r0 has no counter: it can never be pending
  logic [CW-1:0]     cnt [1:N_REGS-1];
  logic [N_REGS-1:0] busy;

  // bit k: write port taken k cycles ahead;
  // bit WB_MUL is only ever the zero fill
  logic [WB_MUL:1]   wbres;
  logic [WB_MUL:1]   wbres_nxt;

  logic is_mul;
  logic is_load;
  logic is_alu;
  logic writes;
  logic raw;
  logic waw;
  logic wbc;
  logic upd;

  // per-register busy vector from the counters
  always_comb begin
    busy = '0;
    for (int i = 1; i < N_REGS; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  assign busy_regs = busy;

  // instruction class decode, mul takes priority
  always_comb begin
    is_mul  = 1'b0;
    is_load = 1'b0;
    is_alu  = 1'b0;
    unique case (1'b1)
      dec_flag_mul:
        is_mul = 1'b1;
      (!dec_flag_mul && dec_flag_mem &&
       !dec_flag_store):
        is_load = 1'b1;
      (!dec_flag_mul &&
       !(dec_flag_mem && !dec_flag_store) &&
       dec_flag_reg):
        is_alu = 1'b1;
      default: ;
    endcase
  end

  assign writes = dec_flag_reg &&
                  (dec_dst != 5'd0);

  assign raw = (dec_uses_r1 && busy[dec_r1]) ||
               (dec_uses_r2 && busy[dec_r2]);

  assign waw = writes && busy[dec_dst];

  assign wbc = writes &&
               (is_mul ? wbres[WB_MUL]
                       : wbres[WB_ALU]);

  assign stall = dec_valid && (raw || waw || wbc);

  assign issue = dec_valid && !stall &&
                 !pipe_freeze;

  assign upd = issue && writes;

  // age reservations and book the new writer
  always_comb begin
    wbres_nxt = wbres >> 1;
    if (upd && is_mul)
      wbres_nxt[WB_MUL-1] = 1'b1;
    if (upd && (is_load || is_alu))
      wbres_nxt[WB_ALU-1] = 1'b1;
  end

  // counter and reservation state, held on freeze
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < N_REGS; i++) begin
        cnt[i] <= '0;
      end
      wbres <= '0;
    end else if (!pipe_freeze) begin
      wbres <= wbres_nxt;
      for (int i = 1; i < N_REGS; i++) begin
        if (upd && is_mul &&
            dec_dst == 5'(i))
          cnt[i] <= CW'(MUL_LAT - 1);
        else if (upd && is_load &&
                 dec_dst == 5'(i))
          cnt[i] <= CW'(LD_USE - 1);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

endmodule
